shift_seq: RTL and testbench
============================

# shift_seq

Multi-cycle shift sequencer for the MIPS datapath's shift unit. It replaces a full 32-bit barrel shift in the execute stage with an iterative engine that shifts by at most STEP bits per cycle. It raises `busy` so the hazard/stall logic freezes the pipeline until `done`. It serves SLL/SRL/SRA and their variable forms (SLLV/SRLV/SRAV); the controller supplies the shift amount from `shamt` or `rs[4:0]`.

## Interface
- STEP, 4, max bits shifted per cycle; legal values 1, 2, 4, 8, 16, 32
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR (see Configuration)
- a  in  32  operand, latched on accepted start
- bits  in  5  shift amount 0..31, latched on accepted start
- flush  in  1  synchronous abort (pipeline flush)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse, result valid
- result  out  32  shifted value, registered

## Operation
- States: IDLE, RUN, DONE. Internal registers: acc[31:0], rem[4:0], op_q[1:0].
- IDLE + start:
  - latch acc=a, rem=bits, op_q=op.
  - next state is RUN if bits!=0, else DONE.
- RUN, each cycle:
  - k = min(rem, STEP).
  - acc shifted by k per op_q; rem -= k.
  - if the new rem == 0, next state is DONE.
- Shift rules per step:
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill with acc[31]. The sign is preserved across steps, so the result equals `a >>> bits`.
  - ROTR: bits leaving the LSB re-enter at the MSB.
- DONE:
  - result = acc, done=1 for exactly this cycle.
  - next state is IDLE.
- result holds its value until the next DONE. It is not updated during RUN or by flush.
- start while busy (RUN or DONE) is ignored and not queued.
- flush:
  - in any state, next state is IDLE; no done pulse; result unchanged.
  - flush has priority over start in the same cycle, and over the RUN→DONE transition.
- rst, at any time, including mid-operation: state=IDLE, acc=0, rem=0, op_q=0, result=0, busy=0, done=0.
- bits is unsigned. No arithmetic exceeds 5 bits for rem, and rem never underflows because k ≤ rem.

## Timing
- Start accepted at edge T.
- busy is high from cycle T+1 through the DONE cycle inclusive.
- done is high in cycle T+1+ceil(bits/STEP).
  - bits=0: done at T+1.
  - STEP=32: done at T+2 for any nonzero bits.
- result is valid from the done cycle onward.
- Back-to-back requests: the earliest next acceptance is the cycle after DONE (IDLE). Minimum spacing is ceil(bits/STEP)+2 cycles.
- All outputs are registered or decoded from state registers only; there is no combinational path from inputs to outputs.

## Configuration
- SHIFT_SEQ_ROTR_EN defined:
  - op=11 performs rotate-right (MIPS32r2 ROTR/ROTRV).
- Undefined:
  - op=11 behaves exactly as SRL (01).
  - No rotate logic is synthesized.

## Test plan
- STEP=4, SLL a=0x00000001 bits=31 → busy for 9 cycles; done at T+9; result=0x80000000.
- SRA a=0x80000000 bits=4 → done at T+2; result=0xF8000000. SRL with the same inputs → 0x08000000.
- bits=0, a=0xDEADBEEF, any op → done at T+1; result=0xDEADBEEF.
- Start SLL a=0x1 bits=8, then pulse start with a=0xFF bits=1 at T+1 → second request ignored; result=0x00000100 at T+3.
- Start SRL a=0xFFFFFFFF bits=20; flush at T+2 → no done pulse; busy=0 at T+3; result keeps its prior value. rst asserted mid-RUN → all outputs 0 immediately.
- ROTR a=0x12345678 bits=8 → with SHIFT_SEQ_ROTR_EN, result=0x78123456; without it, result=0x00123456.

Source files
------------

// File: rtl/shift_seq.sv
// shift_seq: iterative shift engine for the MIPS shift unit.
// Each RUN cycle shifts the operand by at most STEP bits. busy stays high
// until the one-cycle done pulse.
// Optional feature macro: SHIFT_SEQ_ROTR_EN (op=11 rotates right; otherwise it is SRL).
module shift_seq #(
   parameter int STEP = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [4:0]  bits,
   input  logic        flush,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   // STEP may be 32, which needs 6 bits.
   localparam logic [5:0] STEP_W = 6'(STEP);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_acc;
   logic [31:0] r_result;
   logic [4:0]  r_rem;
   logic [1:0]  r_op;
   logic [5:0]  w_k;
   logic [4:0]  w_rem_step;
   logic [31:0] w_acc_step;

   // Shift v by k (k <= 31) using the latched op.
   // The sign bit survives every partial step, so chained SRA steps equal a single a >>> bits.
   function automatic logic [31:0] shift_step(input logic [1:0]  op_i,
                                              input logic [31:0] v,
                                              input logic [5:0]  k);
      logic [31:0] res;
      case (op_i)
         2'b00:   res = v << k;
         2'b10:   res = $signed(v) >>> k;
`ifdef SHIFT_SEQ_ROTR_EN
         2'b11:   res = (v >> k) | (v << (6'd32 - k));
         default: res = v >> k;
`else
         default: res = v >> k;
`endif
      endcase
      return res;
   endfunction

   // Step size k = min(rem, STEP), plus the accumulator and remainder after this step.
   always_comb begin
      w_k        = ({1'b0, r_rem} >= STEP_W) ? STEP_W : {1'b0, r_rem};
      w_rem_step = r_rem - w_k[4:0];
      w_acc_step = shift_step(r_op, r_acc, w_k);
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state logic. flush wins over start and over the RUN->DONE transition.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start && !flush)
               w_state_nxt = (bits == 5'd0) ? S_DONE : S_RUN;
         end
         S_RUN: begin
            if (flush)
               w_state_nxt = S_IDLE;
            else if (w_rem_step == 5'd0)
               w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Operand latch, per-step shifting, and the result register.
   // The result is loaded on entry to DONE, so it is valid in the done cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc    <= '0;
         r_rem    <= '0;
         r_op     <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start && !flush) begin
                  r_acc <= a;
                  r_rem <= bits;
                  r_op  <= op;
                  if (bits == 5'd0)
                     r_result <= a;
               end
            end
            S_RUN: begin
               if (!flush) begin
                  r_acc <= w_acc_step;
                  r_rem <= w_rem_step;
                  if (w_rem_step == 5'd0)
                     r_result <= w_acc_step;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy   = (r_state != S_IDLE);
   assign done   = (r_state == S_DONE);
   assign result = r_result;

endmodule

// File: tb/tb_shift_seq.sv
// Testbench for shift_seq.
// A cycle-level model derives busy/done/result from the operation latency ceil(bits/STEP)
// and a one-shot reference shift. Directed cases pin literal values.
// Honors SHIFT_SEQ_ROTR_EN in the same way as the design.
module tb_shift_seq;

   localparam int STEP = 4;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [4:0]  bits;
   logic        flush;
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks;
   int errors;

   shift_seq #(.STEP(STEP)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .bits   (bits),
      .flush  (flush),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One-shot reference shift, computed from the operation's definition.
   function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] v,
                                             input logic [4:0] n);
      int sh;
      sh = 32 - int'(n);
      case (o)
         2'b00:   return v << n;
         2'b01:   return v >> n;
         2'b10:   return $signed(v) >>> n;
`ifdef SHIFT_SEQ_ROTR_EN
         default: return (n == 5'd0) ? v : ((v >> n) | (v << sh));
`else
         default: return v >> n;
`endif
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: m_cnt = remaining busy cycles (0 means idle, 1 means the done cycle).
   int          m_cnt;
   logic [31:0] m_pend;
   logic [31:0] m_result;

   // Model update at each edge, then compare just after the edge.
   always @(posedge clk) begin
      if (rst) begin
         m_cnt    = 0;
         m_result = '0;
      end else begin
         if (flush)
            m_cnt = 0;
         else if (m_cnt == 0) begin
            if (start) begin
               m_cnt  = 1 + (int'(bits) + STEP - 1) / STEP;
               m_pend = ref_shift(op, a, bits);
            end
         end else
            m_cnt = m_cnt - 1;
         if (m_cnt == 1)
            m_result = m_pend;
      end
      #1;
      chk("model_busy",   {31'd0, busy}, {31'd0, (m_cnt > 0)});
      chk("model_done",   {31'd0, done}, {31'd0, (m_cnt == 1)});
      chk("model_result", result, m_result);
   end

   // Issue one start pulse. On return, the simulation is at the negedge of cycle T+1.
   task automatic issue(input logic [1:0] o, input logic [31:0] v, input logic [4:0] n);
      @(negedge clk);
      start = 1'b1; op = o; a = v; bits = n;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait for done (bounded). Check its cycle index (T+lat) and the result.
   task automatic wait_done(input string name, input int exp_lat, input logic [31:0] exp_res);
      int lat;
      lat = 1;
      while (!done && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({name, "_result"}, result, exp_res);
      @(negedge clk);
      chk({name, "_idle_after"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic [31:0] prior;
      int busy_cnt;
      checks = 0;
      errors = 0;
      rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; bits = '0; flush = 1'b0;
      #2;
      chk("reset_busy",   {31'd0, busy}, 32'd0);
      chk("reset_done",   {31'd0, done}, 32'd0);
      chk("reset_result", result, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // SLL 1 by 31: busy for 9 cycles, done at T+9.
      issue(2'b00, 32'h0000_0001, 5'd31);
      busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (busy) busy_cnt++;
         if (done) break;
         @(negedge clk);
      end
      chk("sll31_busy_cycles", 32'(busy_cnt), 32'd9);
      chk("sll31_result", result, 32'h8000_0000);
      @(negedge clk);

      issue(2'b10, 32'h8000_0000, 5'd4);
      wait_done("sra4", 2, 32'hF800_0000);
      issue(2'b01, 32'h8000_0000, 5'd4);
      wait_done("srl4", 2, 32'h0800_0000);
      issue(2'b00, 32'hDEAD_BEEF, 5'd0);
      wait_done("sll0", 1, 32'hDEAD_BEEF);
      issue(2'b10, 32'hDEAD_BEEF, 5'd0);
      wait_done("sra0", 1, 32'hDEAD_BEEF);
      issue(2'b10, 32'h8765_4321, 5'd31);
      wait_done("sra31", 9, 32'hFFFF_FFFF);
      issue(2'b00, 32'h0000_0003, 5'd5);
      wait_done("sll5", 3, 32'h0000_0060);

      // A second start while busy is ignored.
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 32'h0000_0001; bits = 5'd8;
      @(negedge clk);
      a = 32'h0000_00FF; bits = 5'd1;
      @(negedge clk);
      start = 1'b0;
      chk("ignored_start_not_done_T2", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("ignored_start_done_T3", {31'd0, done}, 32'd1);
      chk("ignored_start_result", result, 32'h0000_0100);
      @(negedge clk);

      // A flush mid-RUN produces no done pulse and leaves the result unchanged.
      prior = result;
      issue(2'b01, 32'hFFFF_FFFF, 5'd20);
      chk("flush_no_done_T1", {31'd0, done}, 32'd0);
      @(negedge clk);
      flush = 1'b1;
      chk("flush_no_done_T2", {31'd0, done}, 32'd0);
      @(negedge clk);
      flush = 1'b0;
      chk("flush_busy_T3", {31'd0, busy}, 32'd0);
      chk("flush_done_T3", {31'd0, done}, 32'd0);
      chk("flush_result_kept", result, prior);
      repeat (3) @(negedge clk);

      // Asynchronous reset mid-RUN clears all outputs at once.
      issue(2'b00, 32'h0000_0001, 5'd8);
      wait_done("pre_rst", 3, 32'h0000_0100);
      issue(2'b01, 32'hFFFF_FFFF, 5'd20);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_busy",   {31'd0, busy}, 32'd0);
      chk("rst_mid_done",   {31'd0, done}, 32'd0);
      chk("rst_mid_result", result, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      issue(2'b11, 32'h1234_5678, 5'd8);
`ifdef SHIFT_SEQ_ROTR_EN
      wait_done("rotr8", 3, 32'h7812_3456);
`else
      wait_done("rotr8", 3, 32'h0012_3456);
`endif

      // Random traffic. start, flush and operands change every cycle.
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) == 0);
         flush = ($urandom_range(0, 19) == 0);
         op    = 2'($urandom_range(0, 3));
         a     = $urandom;
         bits  = 5'($urandom_range(0, 31));
      end
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      repeat (12) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
